vga_memory_scanner: RTL and testbench



---
 rtl/vga_memory_scanner.sv | 185 ++++++++++++++++++
 tb/tb_vga_memory_scanner.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_memory_scanner.sv
// VGA 640x480@60 scanner: pixel timing from a 2:1 phase of clk, reads one memory
// word per 40x30 tile and shows its low 24 bits as the tile colour.
module vga_memory_scanner #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int TILE_W    = 40,
    parameter int TILE_H    = 30
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  addressForVga,
    input  logic [31:0] rdataForVga,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        pix_en,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int TXW = $clog2(TILE_W + 1);
    localparam int TYW = $clog2(TILE_H + 1);

    localparam logic [HW-1:0]  H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_VIS      = HW'(H_VISIBLE);
    localparam logic [HW-1:0]  H_VIS_LAST = HW'(H_VISIBLE - 1);
    localparam logic [HW-1:0]  HS_START   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0]  HS_END     = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0]  V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_VIS      = VW'(V_VISIBLE);
    localparam logic [VW-1:0]  V_VIS_LAST = VW'(V_VISIBLE - 1);
    localparam logic [VW-1:0]  VS_START   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0]  VS_END     = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [TXW-1:0] TX_LAST    = TXW'(TILE_W - 1);
    localparam logic [TYW-1:0] TY_LAST    = TYW'(TILE_H - 1);

    logic           phase_q, phase_d;
    logic [HW-1:0]  hcnt_q, hcnt_d;
    logic [VW-1:0]  vcnt_q, vcnt_d;
    logic [TXW-1:0] tx_q, tx_d;
    logic [TYW-1:0] ty_q, ty_d;
    logic [3:0]     col_q, col_d;
    logic [3:0]     row_q, row_d;
    logic [7:0]     addr_q, addr_d;
    logic [7:0]     red_q, red_d;
    logic [7:0]     green_q, green_d;
    logic [7:0]     blue_q, blue_d;
    logic           blank_n_q, blank_n_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           pix_en_q, pix_en_d;
    logic           frame_start_q, frame_start_d;
    logic           visible_s;
    logic           rdata_unused_s;

    assign visible_s      = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
    assign rdata_unused_s = ^rdataForVga[31:24];

    // Next-state: address on phase 0, video sample and counter advance on phase 1.
    always_comb begin
        phase_d       = ~phase_q;
        pix_en_d      = ~phase_q;
        frame_start_d = ~phase_q & (hcnt_q == '0) & (vcnt_q == '0);
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        tx_d          = tx_q;
        ty_d          = ty_q;
        col_d         = col_q;
        row_d         = row_q;
        addr_d        = addr_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        blank_n_d     = blank_n_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        if (!phase_q) begin
            addr_d = {row_q, col_q};
        end else begin
            blank_n_d = visible_s;
            red_d     = visible_s ? rdataForVga[23:16] : 8'h00;
            green_d   = visible_s ? rdataForVga[15:8]  : 8'h00;
            blue_d    = visible_s ? rdataForVga[7:0]   : 8'h00;
            hsync_d   = ~((hcnt_q >= HS_START) && (hcnt_q < HS_END));
            vsync_d   = ~((vcnt_q >= VS_START) && (vcnt_q < VS_END));
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                tx_d   = '0;
                col_d  = 4'h0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = '0;
                    ty_d   = '0;
                    row_d  = 4'h0;
                end else begin
                    vcnt_d = vcnt_q + VW'(1);
                    // Row stops on the last visible line so it holds 15 through vblank.
                    if (vcnt_q < V_VIS_LAST) begin
                        if (ty_q == TY_LAST) begin
                            ty_d  = '0;
                            row_d = row_q + 4'h1;
                        end else begin
                            ty_d  = ty_q + TYW'(1);
                        end
                    end else begin
                        ty_d = ty_q;
                    end
                end
            end else begin
                hcnt_d = hcnt_q + HW'(1);
                if (hcnt_q < H_VIS_LAST) begin
                    if (tx_q == TX_LAST) begin
                        tx_d  = '0;
                        col_d = col_q + 4'h1;
                    end else begin
                        tx_d  = tx_q + TXW'(1);
                    end
                end else begin
                    tx_d = tx_q;
                end
            end
        end
    end

    // State registers with synchronous reset to the start of a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q       <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            tx_q          <= '0;
            ty_q          <= '0;
            col_q         <= 4'h0;
            row_q         <= 4'h0;
            addr_q        <= 8'h00;
            red_q         <= 8'h00;
            green_q       <= 8'h00;
            blue_q        <= 8'h00;
            blank_n_q     <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            pix_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            tx_q          <= tx_d;
            ty_q          <= ty_d;
            col_q         <= col_d;
            row_q         <= row_d;
            addr_q        <= addr_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            blank_n_q     <= blank_n_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            pix_en_q      <= pix_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign addressForVga = addr_q;
    assign red           = red_q;
    assign green         = green_q;
    assign blue          = blue_q;
    assign blank_n       = blank_n_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign pix_en        = pix_en_q;
    assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_memory_scanner.sv
// Bench for vga_memory_scanner on a scaled-down raster; a closed-form model of the
// raster feeds a scoreboard queue every clk, plus measured sync/blank/frame geometry.
module tb_vga_memory_scanner;

    localparam int HV = 64, HF = 4, HS = 6, HB = 6;
    localparam int VV = 32, VF = 2, VS = 2, VB = 3;
    localparam int TW = 4, TH = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  addr;
    logic [31:0] rdata;
    logic        hsync, vsync, blank_n, pix_en, frame_start;
    logic [7:0]  red, green, blue;
    logic [31:0] mem [256];

    assign rdata = mem[addr];

    vga_memory_scanner #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .TILE_W(TW), .TILE_H(TH)
    ) dut (
        .clk(clk), .reset(reset), .addressForVga(addr), .rdataForVga(rdata),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .red(red), .green(green), .blue(blue),
        .pix_en(pix_en), .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       pix_en;
        logic       frame_start;
        logic       hsync;
        logic       vsync;
        logic       blank_n;
        logic [7:0] addr;
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } obs_t;

    typedef struct {
        logic rst;
        int   cycles;
        int   exp_fs;
        int   exp_pix;
    } vec_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   k = 0;
    int   fs_seen = 0;
    int   pix_seen = 0;

    function automatic logic [7:0] tile(input int p);
        int h, v;
        logic [3:0] r, c;
        h = p % HT;
        v = (p / HT) % VT;
        c = (h < HV) ? 4'(h / TW) : 4'd15;
        r = (v < VV) ? 4'(v / TH) : 4'd15;
        return {r, c};
    endfunction

    // Outputs expected kk clks after the last reset clk.
    function automatic obs_t model(input int kk);
        obs_t e;
        int p, h, v, pv, hv, vv;
        logic vis;
        logic [31:0] w;
        p = kk / 2;
        h = p % HT;
        v = (p / HT) % VT;
        e.pix_en      = (kk % 2 == 1);
        e.frame_start = (kk % 2 == 1) && (h == 0) && (v == 0);
        e.addr        = (kk == 0) ? 8'h00 : tile((kk - 1) / 2);
        if (kk < 2) begin
            e.blank_n = 1'b0;
            e.red     = 8'h00;
            e.green   = 8'h00;
            e.blue    = 8'h00;
            e.hsync   = 1'b1;
            e.vsync   = 1'b1;
        end else begin
            pv  = kk / 2 - 1;
            hv  = pv % HT;
            vv  = (pv / HT) % VT;
            vis = (hv < HV) && (vv < VV);
            w   = mem[tile(pv)];
            e.blank_n = vis;
            e.red     = vis ? w[23:16] : 8'h00;
            e.green   = vis ? w[15:8]  : 8'h00;
            e.blue    = vis ? w[7:0]   : 8'h00;
            e.hsync   = !((hv >= HV + HF) && (hv < HV + HF + HS));
            e.vsync   = !((vv >= VV + VF) && (vv < VV + VF + VS));
        end
        return e;
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic step(input logic rst);
        obs_t got, want;
        reset = rst;
        @(posedge clk);
        k = rst ? 0 : k + 1;
        exp_q.push_back(model(k));
        @(negedge clk);
        got  = {pix_en, frame_start, hsync, vsync, blank_n, addr, red, green, blue};
        want = exp_q.pop_front();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL outputs k=%0d: got %h, want %h", k, got, want);
        end
        fs_seen  += int'(frame_start);
        pix_seen += int'(pix_en);
    endtask

    initial begin
        vec_t vt[4];
        int n, cnt, hi, lo, tl, vs_off;

        for (int i = 0; i < 256; i++) mem[i] = {8'h00, 16'h0000, 8'(i)};
        mem[8'h35] = 32'h12ABCDEF;

        vt[0] = '{1'b1, 3, 0, 0};
        vt[1] = '{1'b0, 4, 1, 2};
        vt[2] = '{1'b0, 2 * FRAME - 4, 0, FRAME - 2};
        vt[3] = '{1'b0, 2, 1, 1};
        for (int i = 0; i < 4; i++) begin
            fs_seen  = 0;
            pix_seen = 0;
            repeat (vt[i].cycles) step(vt[i].rst);
            check($sformatf("seg%0d frame_start count", i), fs_seen, vt[i].exp_fs);
            check($sformatf("seg%0d pix_en count", i), pix_seen, vt[i].exp_pix);
        end

        // Line geometry: blank_n width, hsync offset from line start and width.
        n = 0;
        while (blank_n === 1'b1 && n < 4 * HT) begin step(1'b0); n++; end
        n = 0;
        while (blank_n !== 1'b1 && n < 4 * HT) begin step(1'b0); n++; end
        check("line start found", int'(n < 4 * HT), 1);
        cnt = 0;
        while (blank_n === 1'b1 && cnt < 4 * HT) begin step(1'b0); cnt++; end
        check("blank_n high clks", cnt, 2 * HV);
        n = 0;
        while (hsync !== 1'b0 && n < 4 * HT) begin step(1'b0); n++; end
        check("hsync fall offset clks", cnt + n, 2 * (HV + HF));
        cnt = 0;
        while (hsync === 1'b0 && cnt < 4 * HT) begin step(1'b0); cnt++; end
        check("hsync low clks", cnt, 2 * HS);

        // Frame geometry between consecutive frame_start pulses.
        n = 0;
        while (frame_start !== 1'b1 && n < 2 * FRAME + 4) begin step(1'b0); n++; end
        check("frame_start found", int'(n < 2 * FRAME + 4), 1);
        n = 0; hi = 0; lo = 0; tl = 0; vs_off = -1;
        do begin
            step(1'b0);
            n++;
            hi += int'(blank_n === 1'b1);
            lo += int'(vsync === 1'b0);
            tl += int'({red, green, blue} === 24'hABCDEF);
            if (vsync === 1'b0 && vs_off < 0) vs_off = n;
        end while (frame_start !== 1'b1 && n < 2 * FRAME + 4);
        check("frame length clks", n, 2 * FRAME);
        check("blank_n high clks per frame", hi, 2 * HV * VV);
        check("vsync low clks", lo, 2 * HT * VS);
        check("vsync fall offset clks", vs_off, 2 * HT * (VV + VF) + 1);
        check("tile 0x35 colour clks", tl, 2 * TW * TH);

        // Reset in the middle of a frame, then a clean restart from (0,0).
        n = 0;
        while (!((k % 2 == 1) && ((k / 2) % FRAME == 20 * HT + 30)) && n < 2 * FRAME + 4) begin
            step(1'b0);
            n++;
        end
        check("mid-frame point reached", int'(n < 2 * FRAME + 4), 1);
        step(1'b1);
        check("reset frame_start", int'(frame_start), 0);
        check("reset pix_en", int'(pix_en), 0);
        check("reset addr", int'(addr), 0);
        check("reset hsync", int'(hsync), 1);
        step(1'b0);
        check("restart frame_start", int'(frame_start), 1);
        check("restart addr", int'(addr), 0);
        step(1'b0);
        check("restart addr reissued", int'(addr), 0);
        repeat (6 * HT) step(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
